// File: rtl/patch_pkg.sv
// Shared definitions for the patch scheduler.
//   pf_state_e      : encoding of the patchifier state seen on pf_state
//   sched_state_e   : scheduler FSM states
//   DefaultNumPatches : default number of patches in one frame
package patch_pkg;

  localparam int unsigned DefaultNumPatches = 16;

  typedef enum logic [1:0] {
    PfIdle       = 2'b00,
    PfProcessing = 2'b01,
    PfDone       = 2'b10
  } pf_state_e;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitPf,
    StStream,
    StDrain,
    StRelease
  } sched_state_e;

endpackage

// File: rtl/patch_scheduler.sv
// Frame-level scheduler between a patchifier and a downstream patch consumer.
// A start request launches the patchifier, waits for it to finish, then offers
// TOTAL_NUM_PATCHES patch indices over a valid/ready handshake and finally
// releases the patchifier's output. An abort cancels the frame cleanly.
//
// Ports
//   clk             in   single clock
//   reset           in   asynchronous active-low reset
//   start           in   frame request, only honoured when idle
//   abort           in   cancel the current frame
//   busy            out  high whenever not idle
//   frame_done      out  one-cycle pulse on normal completion
//   frame_aborted   out  one-cycle pulse when an aborted frame is released
//   pf_en           out  patchifier enable
//   pf_output_taken out  patchifier release pulse
//   pf_state        in   patchifier state (00 idle, 01 processing, 10 done)
//   patch_valid     out  patch offer
//   patch_ready     in   downstream accept
//   patch_idx       out  index of the offered patch
//   patch_last      out  offered patch is the final one of the frame
module patch_scheduler
  import patch_pkg::*;
#(
  parameter int unsigned TOTAL_NUM_PATCHES = DefaultNumPatches,
  parameter int unsigned PATCH_IDX_W       = $clog2(TOTAL_NUM_PATCHES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_aborted,
  output logic                   pf_en,
  output logic                   pf_output_taken,
  input  logic [1:0]             pf_state,
  output logic                   patch_valid,
  input  logic                   patch_ready,
  output logic [PATCH_IDX_W-1:0] patch_idx,
  output logic                   patch_last
);

  localparam logic [PATCH_IDX_W-1:0] LastIdx = PATCH_IDX_W'(TOTAL_NUM_PATCHES - 1);
  localparam logic [PATCH_IDX_W-1:0] IdxOne  = PATCH_IDX_W'(1);

  sched_state_e           state_q;
  logic [PATCH_IDX_W-1:0] idx_q;
  logic                   valid_q;
  logic                   last_q;
  logic                   taken_q;
  logic                   done_q;
  logic                   aborted_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      taken_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      taken_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_q <= StLaunch;
          end
        end
        StLaunch: begin
          if (abort) begin
            if (pf_state == PfIdle) begin
              // Patchifier never started: nothing to release.
              state_q   <= StIdle;
              aborted_q <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end else if (pf_state != PfIdle) begin
            // A patchifier that jumps straight to done is still treated as started.
            state_q <= StWaitPf;
          end
        end
        StWaitPf: begin
          if (abort) begin
            state_q <= StDrain;
          end else if (pf_state == PfDone) begin
            state_q <= StStream;
            idx_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= (LastIdx == '0);
          end
        end
        StStream: begin
          // Abort wins over a coincident handshake; that patch is not accepted.
          if (abort) begin
            state_q <= StDrain;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else if (valid_q && patch_ready) begin
            if (last_q) begin
              state_q <= StRelease;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              taken_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= idx_q + IdxOne;
              last_q <= ((idx_q + IdxOne) == LastIdx);
            end
          end
        end
        StDrain: begin
          // The patchifier must reach done before its output can be released.
          if (pf_state == PfDone) begin
            state_q   <= StRelease;
            taken_q   <= 1'b1;
            aborted_q <= 1'b1;
          end
        end
        StRelease: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy            = (state_q != StIdle);
  assign pf_en           = (state_q == StLaunch) && (pf_state == PfIdle);
  assign pf_output_taken = taken_q;
  assign frame_done      = done_q;
  assign frame_aborted   = aborted_q;
  assign patch_valid     = valid_q;
  assign patch_idx       = idx_q;
  assign patch_last      = last_q;

endmodule

// File: tb/tb_patch_scheduler.sv
module tb_patch_scheduler;

  localparam int N = 16;
  localparam int W = 4;
  localparam int MIdle = 0, MLaunch = 1, MWait = 2, MStream = 3, MDrain = 4, MRelease = 5;

  logic         clk = 1'b0;
  logic         reset, start, abort, patch_ready;
  logic [1:0]   pf_state;
  logic         busy, frame_done, frame_aborted, pf_en, pf_output_taken, patch_valid, patch_last;
  logic [W-1:0] patch_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: frame phase plus number of patches already accepted.
  int m_phase, m_sent;
  bit m_taken, m_done, m_abp;

  // Stimulus policy.
  int ready_mode, rcnt, abort_idx;
  bit abort_wait, abort_launch, rand_mode;

  // Patchifier emulator.
  int launch_delay, proc_len, pf_cnt;
  bit pf_random;

  // Observations taken from the DUT.
  int obs_hs, obs_done, obs_ab, obs_taken, obs_last_idx;
  int obs_q[$];

  always #5 clk = ~clk;

  patch_scheduler #(
    .TOTAL_NUM_PATCHES(N),
    .PATCH_IDX_W      (W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_aborted  (frame_aborted),
    .pf_en          (pf_en),
    .pf_output_taken(pf_output_taken),
    .pf_state       (pf_state),
    .patch_valid    (patch_valid),
    .patch_ready    (patch_ready),
    .patch_idx      (patch_idx),
    .patch_last     (patch_last)
  );

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    m_taken = 0;
    m_done  = 0;
    m_abp   = 0;
    if (!reset) begin
      m_phase = MIdle;
      m_sent  = 0;
      return;
    end
    case (m_phase)
      MIdle: if (start && !abort) m_phase = MLaunch;
      MLaunch: begin
        if (abort) begin
          if (pf_state == 2'b00) begin
            m_phase = MIdle;
            m_abp   = 1;
          end else m_phase = MDrain;
        end else if (pf_state != 2'b00) m_phase = MWait;
      end
      MWait: begin
        if (abort) m_phase = MDrain;
        else if (pf_state == 2'b10) begin
          m_phase = MStream;
          m_sent  = 0;
        end
      end
      MStream: begin
        if (abort) m_phase = MDrain;
        else if (patch_ready) begin
          if (m_sent == N - 1) begin
            m_phase = MRelease;
            m_taken = 1;
            m_done  = 1;
          end else m_sent++;
        end
      end
      MDrain: begin
        if (pf_state == 2'b10) begin
          m_phase = MRelease;
          m_taken = 1;
          m_abp   = 1;
        end
      end
      default: m_phase = MIdle;
    endcase
  endtask

  task automatic compare_all();
    chk_bit("busy", busy, m_phase != MIdle);
    chk_bit("pf_en", pf_en, (m_phase == MLaunch) && (pf_state == 2'b00));
    chk_bit("patch_valid", patch_valid, m_phase == MStream);
    if (m_phase == MStream) begin
      chk_int("patch_idx", int'(patch_idx), m_sent);
      chk_bit("patch_last", patch_last, m_sent == N - 1);
    end else begin
      chk_bit("patch_last", patch_last, 1'b0);
    end
    chk_bit("pf_output_taken", pf_output_taken, m_taken);
    chk_bit("frame_done", frame_done, m_done);
    chk_bit("frame_aborted", frame_aborted, m_abp);
  endtask

  // Accepted indices of a frame must run 0,1,2,... (all N when completed).
  task automatic check_seq(input string name, input bit full);
    int bad;
    bad = 0;
    if (full && obs_q.size() != N) bad++;
    foreach (obs_q[i]) if (obs_q[i] != i) bad++;
    chk_int(name, bad, 0);
    obs_q.delete();
  endtask

  task automatic monitor(input bit pre_hs, input int pre_idx, input bit pre_last);
    if (!reset) begin
      obs_q.delete();
      return;
    end
    if (pre_hs) begin
      obs_hs++;
      obs_q.push_back(pre_idx);
      if (pre_last) obs_last_idx = pre_idx;
    end
    if (pf_output_taken) obs_taken++;
    if (frame_done) begin
      obs_done++;
      check_seq("frame_seq_done", 1'b1);
    end
    if (frame_aborted) begin
      obs_ab++;
      check_seq("frame_seq_abort", 1'b0);
    end
  endtask

  task automatic emulate_pf();
    if (!reset) begin
      pf_state = 2'b00;
      pf_cnt   = 0;
      return;
    end
    case (pf_state)
      2'b00: begin
        if (pf_en) begin
          pf_cnt++;
          if (pf_cnt >= launch_delay) begin
            pf_state = 2'b01;
            pf_cnt   = 0;
            if (pf_random) proc_len = $urandom_range(1, 5);
          end
        end else pf_cnt = 0;
      end
      2'b01: begin
        pf_cnt++;
        if (pf_cnt >= proc_len) begin
          pf_state = 2'b10;
          pf_cnt   = 0;
        end
      end
      default: begin
        if (pf_output_taken) begin
          pf_state = 2'b00;
          if (pf_random) launch_delay = $urandom_range(1, 3);
        end
      end
    endcase
  endtask

  task automatic drive_policy();
    case (ready_mode)
      0: patch_ready = 1'b1;
      1: begin
        patch_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
        rcnt++;
      end
      default: patch_ready = ($urandom_range(0, 1) == 1);
    endcase
    abort = 1'b0;
    if (abort_idx >= 0 && m_phase == MStream && m_sent == abort_idx) begin
      abort     = 1'b1;
      abort_idx = -1;
    end
    if (abort_wait && m_phase == MWait) begin
      abort      = 1'b1;
      abort_wait = 0;
    end
    if (abort_launch && m_phase == MLaunch && pf_state == 2'b00 && pf_cnt == 1) begin
      abort        = 1'b1;
      abort_launch = 0;
    end
    if (rand_mode) begin
      if ($urandom_range(0, 99) < 3) abort = 1'b1;
      start = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic cycle();
    bit pre_hs, pre_last;
    int pre_idx;
    pre_hs   = reset && patch_valid && patch_ready && !abort;
    pre_idx  = int'(patch_idx);
    pre_last = patch_last;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    monitor(pre_hs, pre_idx, pre_last);
    emulate_pf();
  endtask

  task automatic reset_obs();
    obs_hs = 0; obs_done = 0; obs_ab = 0; obs_taken = 0; obs_last_idx = -1;
    rcnt = 0;
  endtask

  task automatic run_until_idle(input int bound, input string name);
    int n;
    bit ended;
    n = 0;
    ended = 0;
    while (n < bound && !(ended && !busy)) begin
      drive_policy();
      cycle();
      n++;
      if (frame_done || frame_aborted) ended = 1;
    end
    chk_bit({name, "_completes"}, ended && !busy, 1'b1);
  endtask

  task automatic start_frame();
    start = 1'b1;
    drive_policy();
    cycle();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; pf_state = 2'b00; patch_ready = 1'b0;
    ready_mode = 0; abort_idx = -1; abort_wait = 0; abort_launch = 0; rand_mode = 0;
    launch_delay = 1; proc_len = 3; pf_cnt = 0; pf_random = 0;
    m_phase = MIdle; m_sent = 0; m_taken = 0; m_done = 0; m_abp = 0;
    reset_obs();

    // Reset state, before any clock edge.
    #1;
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_valid", patch_valid, 1'b0);
    chk_int("reset_idx", int'(patch_idx), 0);
    chk_bit("reset_pf_en", pf_en, 1'b0);
    repeat (3) cycle();
    #2 reset = 1'b1;

    // Normal frame.
    reset_obs();
    start_frame();
    run_until_idle(200, "normal");
    chk_int("normal_handshakes", obs_hs, 16);
    chk_int("normal_last_idx", obs_last_idx, 15);
    chk_int("normal_taken", obs_taken, 1);
    chk_int("normal_done", obs_done, 1);
    chk_int("normal_aborted", obs_ab, 0);

    // Backpressure 1-0-0-1.
    reset_obs();
    ready_mode = 1;
    start_frame();
    run_until_idle(300, "backpressure");
    chk_int("bp_handshakes", obs_hs, 16);
    chk_int("bp_done", obs_done, 1);
    ready_mode = 0;

    // Abort while streaming index 5.
    reset_obs();
    abort_idx = 5;
    start_frame();
    run_until_idle(200, "abort_stream");
    chk_int("abs_handshakes", obs_hs, 5);
    chk_int("abs_taken", obs_taken, 1);
    chk_int("abs_aborted", obs_ab, 1);
    chk_int("abs_done", obs_done, 0);

    // Abort while the patchifier is processing: drain then release.
    reset_obs();
    proc_len = 6;
    abort_wait = 1;
    start_frame();
    run_until_idle(200, "abort_wait");
    chk_int("abw_handshakes", obs_hs, 0);
    chk_int("abw_taken", obs_taken, 1);
    chk_int("abw_aborted", obs_ab, 1);
    chk_int("abw_done", obs_done, 0);
    proc_len = 3;

    // Abort before the patchifier leaves idle: no release needed.
    reset_obs();
    launch_delay = 3;
    abort_launch = 1;
    start_frame();
    run_until_idle(200, "abort_launch");
    chk_int("abl_taken", obs_taken, 0);
    chk_int("abl_aborted", obs_ab, 1);
    chk_bit("abl_pf_en", pf_en, 1'b0);
    launch_delay = 1;

    // Start while busy is ignored; reset mid-stream abandons the frame.
    reset_obs();
    start_frame();
    for (int i = 0; i < 100 && !(m_phase == MStream && m_sent == 3); i++) begin
      drive_policy();
      cycle();
    end
    chk_bit("rst_reached_stream", patch_valid, 1'b1);
    start = 1'b1;
    drive_policy();
    cycle();
    start = 1'b0;
    drive_policy();
    cycle();
    chk_int("stream_after_start", int'(patch_idx), 5);
    #2 reset = 1'b0;
    #1;
    chk_bit("rst_async_busy", busy, 1'b0);
    chk_bit("rst_async_valid", patch_valid, 1'b0);
    chk_bit("rst_async_last", patch_last, 1'b0);
    chk_int("rst_async_idx", int'(patch_idx), 0);
    chk_bit("rst_async_pf_en", pf_en, 1'b0);
    chk_bit("rst_async_taken", pf_output_taken, 1'b0);
    chk_bit("rst_async_done", frame_done, 1'b0);
    chk_bit("rst_async_aborted", frame_aborted, 1'b0);
    repeat (3) cycle();
    #2 reset = 1'b1;
    repeat (4) begin
      drive_policy();
      cycle();
    end
    chk_int("rst_no_done", obs_done, 0);
    chk_int("rst_no_aborted", obs_ab, 0);
    chk_int("rst_no_taken", obs_taken, 0);

    // Randomized traffic.
    reset_obs();
    rand_mode = 1;
    ready_mode = 2;
    pf_random = 1;
    repeat (3000) begin
      drive_policy();
      cycle();
    end
    rand_mode = 0;
    start = 1'b0;
    for (int i = 0; i < 500 && busy; i++) begin
      drive_policy();
      cycle();
    end
    chk_bit("random_settles", busy, 1'b0);
    chk_bit("random_frames_seen", (obs_done + obs_ab) > 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/patch_scheduler.md
PATCH_SCHEDULER -- requirements
Module: patch_scheduler

Interface
REQ-001 SHALL have parameter TOTAL_NUM_PATCHES, default 16, meaning patches per frame.
REQ-002 SHALL have parameter PATCH_IDX_W, default 4, meaning patch index width, equal to clog2(TOTAL_NUM_PATCHES).
REQ-003 SHALL have port clk  in  1  the single clock.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  frame request, sampled in IDLE only.
REQ-006 SHALL have port abort  in  1  cancel the current frame.
REQ-007 SHALL have port busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port frame_done  out  1  one-cycle pulse when a frame completes normally.
REQ-009 SHALL have port frame_aborted  out  1  one-cycle pulse when an aborted frame is released.
REQ-010 SHALL have port pf_en  out  1  patchifier enable.
REQ-011 SHALL have port pf_output_taken  out  1  patchifier release.
REQ-012 SHALL have port pf_state  in  2  patchifier state: 00 IDLE, 01 PROCESSING, 10 DONE.
REQ-013 SHALL have port patch_valid  out  1  downstream patch offer.
REQ-014 SHALL have port patch_ready  in  1  downstream accept.
REQ-015 SHALL have port patch_idx  out  PATCH_IDX_W  index of the offered patch.
REQ-016 SHALL have port patch_last  out  1  high when patch_idx = TOTAL_NUM_PATCHES-1 and patch_valid is high.

Function
REQ-017 SHALL implement states IDLE, LAUNCH, WAIT_PF, STREAM, DRAIN, RELEASE.
REQ-018 SHALL leave IDLE for LAUNCH on start=1 while abort=0; start outside IDLE SHALL be ignored.
REQ-019 SHALL assert pf_en in LAUNCH while pf_state=00, and move to WAIT_PF on the first cycle pf_state=01.
REQ-020 SHALL move WAIT_PF to STREAM on the cycle pf_state=10 is seen, with patch_idx cleared to 0.
REQ-021 SHALL drive patch_valid, patch_idx and patch_last as registered outputs, asserted from the cycle after STREAM entry.
REQ-022 SHALL hold patch_valid high and patch_idx stable until patch_valid&patch_ready is seen.
REQ-023 SHALL increment patch_idx by 1 on each handshake; the handshake with patch_last=1 SHALL drop patch_valid the next cycle and enter RELEASE.
REQ-024 SHALL, in RELEASE, assert pf_output_taken for exactly one cycle, pulse frame_done (or frame_aborted), and then return to IDLE.
REQ-025 SHALL, on abort=1 in LAUNCH, WAIT_PF or STREAM, drop patch_valid next cycle, go to DRAIN, and skip further handshakes.
REQ-026 SHALL, in DRAIN, wait for pf_state=10 and then enter RELEASE with frame_aborted; if abort comes in LAUNCH before pf_state=01, SHALL deassert pf_en and return to IDLE with frame_aborted.
REQ-027 SHALL give abort priority over a simultaneous handshake; that patch counts as not accepted.
REQ-028 SHALL treat abort in IDLE or RELEASE as a no-op.
REQ-029 SHALL never assert pf_en and pf_output_taken in the same cycle.

Reset
REQ-030 SHALL, while reset=0, force state IDLE, patch_idx=0, and every output low, independent of clk.
REQ-031 SHALL, when reset asserts mid-frame, abandon the frame with no frame_done or frame_aborted pulse.

Structure
REQ-032 SHALL put the pf_state encodings, the scheduler state enum and the TOTAL_NUM_PATCHES default in shared package patch_pkg.
REQ-033 SHALL be a single module with no sub-module; the index counter SHALL be inline.

Verification
REQ-034 Normal frame: start pulse, pf_state 00->01 (3 cycles)->10, patch_ready=1 -> 16 handshakes with idx 0..15, patch_last on idx 15, one pf_output_taken pulse and one frame_done pulse.
REQ-035 Backpressure: patch_ready toggling 1-0-0-1 -> idx holds while ready=0, no index skipped or repeated, 16 handshakes total.
REQ-036 Abort in STREAM at idx 5 -> patch_valid low next cycle, one pf_output_taken pulse, frame_aborted=1, frame_done=0.
REQ-037 Abort in WAIT_PF -> state DRAIN until pf_state=10, then RELEASE, then IDLE.
REQ-038 Start while busy, then reset=0 during STREAM -> second start ignored; all outputs 0 immediately on reset, no done or aborted pulse.
